exception_cause_unit: RTL and testbench

//  Parametrised successor to the 3-input cause-code mux of the multicycle CPU. Queues exception requests
//  and captures the PC of each. Presents one cause at a time, by priority, to the control unit.

---
 rtl/exc_pkg.sv | 16 +
 rtl/exc_prio_enc.sv | 28 ++
 rtl/exception_cause_unit.sv | 180 ++++++++++++++++++
 tb/tb_exception_cause_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// exc_pkg
//   Shared types and constants for the exception cause unit.
//   - exc_state_t : presentation FSM state (IDLE, PRESENT)
//   - EXC_*       : default cause codes for the three legacy sources
package exc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } exc_state_t;

  localparam logic [7:0] EXC_OPCODE = 8'd0;
  localparam logic [7:0] EXC_OVF    = 8'd1;
  localparam logic [7:0] EXC_DIV0   = 8'd2;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc
//   Lowest-index-first priority encoder (index 0 = highest priority).
//   Ports:
//     req  in  N      request vector
//     win  out IDX_W  index of the lowest set bit of req (0 when none)
//     any  out 1      at least one bit of req is set
module exc_prio_enc #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] win,
  output logic             any
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        win = IDX_W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/exception_cause_unit.sv
// exception_cause_unit
//   Queues exception requests (one slot per source, with the PC captured at
//   request time) and presents one cause at a time, lowest source index first,
//   holding it until the control unit acknowledges it.
//   Ports:
//     clk        in   1         rising-edge clock
//     reset      in   1         asynchronous active-high reset
//     exc_req    in   N_CAUSES  per-source request pulse
//     exc_mask   in   N_CAUSES  1 = source disabled (request ignored)
//     pc_in      in   PC_W      PC sampled together with exc_req
//     exc_ack    in   1         control unit accepted the presented cause
//     flush      in   1         synchronous clear of all pending/presented causes
//     clr_lost   in   1         clears the sticky exc_lost flag
//     exc_valid  out  1         a cause is presented
//     cause_out  out  CAUSE_W   code of the presented cause
//     epc_out    out  PC_W      PC captured with the presented cause
//     vec_idx    out  IDX_W     source index of the presented cause
//     pend_cnt   out  CNT_W     number of occupied slots (includes presented one)
//     exc_lost   out  1         sticky: a request hit an already occupied slot
module exception_cause_unit
  import exc_pkg::*;
#(
  parameter int                            N_CAUSES    = 3,
  parameter int                            CAUSE_W     = 8,
  parameter int                            PC_W        = 32,
  parameter logic [N_CAUSES*CAUSE_W-1:0]   CAUSE_TABLE = {EXC_DIV0, EXC_OVF, EXC_OPCODE},
  localparam int                           IDX_W       = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1,
  localparam int                           CNT_W       = $clog2(N_CAUSES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CAUSES-1:0] exc_req,
  input  logic [N_CAUSES-1:0] exc_mask,
  input  logic [PC_W-1:0]     pc_in,
  input  logic                exc_ack,
  input  logic                flush,
  input  logic                clr_lost,
  output logic                exc_valid,
  output logic [CAUSE_W-1:0]  cause_out,
  output logic [PC_W-1:0]     epc_out,
  output logic [IDX_W-1:0]    vec_idx,
  output logic [CNT_W-1:0]    pend_cnt,
  output logic                exc_lost
);

  exc_state_t          state_reg, state_next;
  logic [N_CAUSES-1:0] pend_reg, pend_next;
  logic [PC_W-1:0]     pend_pc_reg  [N_CAUSES];
  logic [PC_W-1:0]     pend_pc_next [N_CAUSES];
  logic [CAUSE_W-1:0]  cause_reg, cause_next;
  logic [PC_W-1:0]     epc_reg, epc_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                lost_reg, lost_next;

  logic [N_CAUSES-1:0] req_eff;
  logic [N_CAUSES-1:0] freed;
  logic [N_CAUSES-1:0] after_clr;
  logic [N_CAUSES-1:0] slot_set;
  logic                ack_fire;
  logic                lost_hit;
  logic [IDX_W-1:0]    win;
  logic                any;

  assign req_eff  = exc_req & ~exc_mask;
  // An ack only counts while something is actually presented.
  assign ack_fire = exc_ack && (state_reg == PRESENT);

  genvar gi;
  generate
    for (gi = 0; gi < N_CAUSES; gi++) begin : g_slot
      // The slot being acknowledged this edge is treated as empty, so a
      // same-cycle re-request refills it instead of counting as a loss.
      assign freed[gi]        = ack_fire && (idx_reg == IDX_W'(gi));
      assign after_clr[gi]    = pend_reg[gi] && !freed[gi];
      assign slot_set[gi]     = req_eff[gi] && !after_clr[gi] && !flush;
      assign pend_pc_next[gi] = slot_set[gi] ? pc_in : pend_pc_reg[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pend_pc_reg[gi] <= '0;
        end else begin
          pend_pc_reg[gi] <= pend_pc_next[gi];
        end
      end
    end
  endgenerate

  assign pend_next = flush ? '0 : (after_clr | slot_set);
  assign lost_hit  = (|(req_eff & after_clr)) && !flush;

  exc_prio_enc #(
    .N     (N_CAUSES),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req (pend_next),
    .win (win),
    .any (any)
  );

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < N_CAUSES; i++) begin
      cnt_next = cnt_next + CNT_W'(pend_next[i]);
    end
  end

  // Set wins over clear when a loss and clr_lost coincide.
  always_comb begin
    lost_next = lost_reg;
    if (lost_hit) begin
      lost_next = 1'b1;
    end else if (clr_lost) begin
      lost_next = 1'b0;
    end
  end

  // Presentation FSM. Outputs are reloaded only when entering PRESENT or on an
  // accepted ack; otherwise they hold (no pre-emption by later requests).
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    epc_next   = epc_reg;
    idx_next   = idx_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any) begin
            state_next = PRESENT;
            cause_next = CAUSE_TABLE[int'(win)*CAUSE_W +: CAUSE_W];
            epc_next   = pend_pc_next[win];
            idx_next   = win;
          end
        end
        PRESENT: begin
          if (ack_fire) begin
            if (any) begin
              cause_next = CAUSE_TABLE[int'(win)*CAUSE_W +: CAUSE_W];
              epc_next   = pend_pc_next[win];
              idx_next   = win;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      cause_reg <= '0;
      epc_reg   <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      lost_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      cause_reg <= cause_next;
      epc_reg   <= epc_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      lost_reg  <= lost_next;
    end
  end

  assign exc_valid = (state_reg == PRESENT);
  assign cause_out = cause_reg;
  assign epc_out   = epc_reg;
  assign vec_idx   = idx_reg;
  assign pend_cnt  = cnt_reg;
  assign exc_lost  = lost_reg;

endmodule

// File: tb/tb_exception_cause_unit.sv
// tb_exception_cause_unit
//   Scoreboard bench: the stimulus process runs a behavioural model of the
//   pending set and pushes expected presentations and per-cycle status into
//   queues; a monitor process pops and compares whatever the DUT shows.
module tb_exception_cause_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  exc_req;
  logic [2:0]  exc_mask;
  logic [31:0] pc_in;
  logic        exc_ack;
  logic        flush;
  logic        clr_lost;
  logic        exc_valid;
  logic [7:0]  cause_out;
  logic [31:0] epc_out;
  logic [1:0]  vec_idx;
  logic [1:0]  pend_cnt;
  logic        exc_lost;

  exception_cause_unit dut (
    .clk       (clk),
    .reset     (reset),
    .exc_req   (exc_req),
    .exc_mask  (exc_mask),
    .pc_in     (pc_in),
    .exc_ack   (exc_ack),
    .flush     (flush),
    .clr_lost  (clr_lost),
    .exc_valid (exc_valid),
    .cause_out (cause_out),
    .epc_out   (epc_out),
    .vec_idx   (vec_idx),
    .pend_cnt  (pend_cnt),
    .exc_lost  (exc_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cause;
    logic [31:0] epc;
    logic [1:0]  idx;
  } pres_t;

  typedef struct {
    bit valid;
    int cnt;
    bit lost;
  } stat_t;

  pres_t pres_q[$];
  stat_t stat_q[$];

  int tests  = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  // Cause code assigned to each source.
  logic [7:0] cause_tab [3] = '{8'd0, 8'd1, 8'd2};

  // Reference model: set of pending sources, captured PCs, presented source.
  bit          m_pend [3];
  logic [31:0] m_pc   [3];
  int          m_cur  = -1;
  bit          m_lost = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs (sampled by the next edge) and advance the model.
  task automatic drive(input logic [2:0] req, input logic [2:0] mask, input logic [31:0] pc,
                       input bit ack, input bit fl, input bit clr);
    bit    lost_now;
    bit    fire;
    int    cnt;
    stat_t s;
    pres_t p;
    @(posedge clk);
    #1;
    exc_req  = req;
    exc_mask = mask;
    pc_in    = pc;
    exc_ack  = ack;
    flush    = fl;
    clr_lost = clr;
    lost_now = 1'b0;
    if (fl) begin
      for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
      m_cur = -1;
    end else begin
      fire = ack && (m_cur >= 0);
      if (fire) m_pend[m_cur] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (req[i] && !mask[i]) begin
          if (m_pend[i]) lost_now = 1'b1;
          else begin
            m_pend[i] = 1'b1;
            m_pc[i]   = pc;
          end
        end
      end
      if (m_cur < 0 || fire) begin
        m_cur = -1;
        for (int i = 2; i >= 0; i--) if (m_pend[i]) m_cur = i;
        if (m_cur >= 0) begin
          p.cause = cause_tab[m_cur];
          p.epc   = m_pc[m_cur];
          p.idx   = 2'(m_cur);
          pres_q.push_back(p);
        end
      end
    end
    if (lost_now) m_lost = 1'b1;
    else if (clr) m_lost = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) cnt += int'(m_pend[i]);
    s.valid = (m_cur >= 0);
    s.cnt   = cnt;
    s.lost  = m_lost;
    stat_q.push_back(s);
    if (!mon_en) mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(3'b000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares each cycle's status and every new presentation.
  initial begin : monitor
    bit    prev_valid;
    bit    prev_ack;
    stat_t s;
    pres_t p;
    pres_t last;
    last.cause = 8'h0;
    last.epc   = 32'h0;
    last.idx   = 2'h0;
    wait (mon_en);
    prev_valid = exc_valid;
    prev_ack   = exc_ack;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!mon_en) break;
      if (stat_q.size() == 0) begin
        check("stat_underflow", 64'd1, 64'd0);
      end else begin
        s = stat_q.pop_front();
        check("status", {exc_valid, 2'(pend_cnt), exc_lost}, {s.valid, 2'(s.cnt), s.lost});
      end
      if (exc_valid && (!prev_valid || prev_ack)) begin
        if (pres_q.size() == 0) begin
          check("pres_underflow", 64'd1, 64'd0);
        end else begin
          p = pres_q.pop_front();
          $display("[TB] present cause=%0d epc=%08h idx=%0d", cause_out, epc_out, vec_idx);
          check("present", {cause_out, epc_out, vec_idx}, {p.cause, p.epc, p.idx});
          last = p;
        end
      end else begin
        check("hold", {cause_out, epc_out, vec_idx}, {last.cause, last.epc, last.idx});
      end
      prev_valid = exc_valid;
      prev_ack   = exc_ack;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset    = 1'b1;
    exc_req  = '0;
    exc_mask = '0;
    pc_in    = '0;
    exc_ack  = 1'b0;
    flush    = 1'b0;
    clr_lost = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 1'b0;
      m_pc[i]   = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_valid", 64'(exc_valid), 64'd0);
    check("reset_outs", {cause_out, epc_out, vec_idx, pend_cnt, exc_lost}, 64'd0);

    // 1: single overflow request
    drive(3'b010, 3'b000, 32'h40, 1'b0, 1'b0, 1'b0);
    idle(1);
    drive(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    // 2: opcode + div0 together; opcode first, then div0 without a bubble
    drive(3'b101, 3'b000, 32'h80, 1'b0, 1'b0, 1'b0);
    idle(1);
    drive(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    // 3: higher-priority request while presenting is queued, not pre-empting
    drive(3'b100, 3'b000, 32'h100, 1'b0, 1'b0, 1'b0);
    drive(3'b001, 3'b000, 32'h104, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    // 4: duplicate request on a pending slot is lost; then clear the flag
    drive(3'b010, 3'b000, 32'h200, 1'b0, 1'b0, 1'b0);
    drive(3'b010, 3'b000, 32'h204, 1'b0, 1'b0, 1'b0);
    drive(3'b000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
    // ack with same-cycle re-request refills the slot without loss
    drive(3'b010, 3'b000, 32'h208, 1'b1, 1'b0, 1'b0);
    drive(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    // 5: masked request ignored
    drive(3'b100, 3'b100, 32'h300, 1'b0, 1'b0, 1'b0);
    idle(2);
    // 6: flush with a same-cycle request
    drive(3'b011, 3'b000, 32'h400, 1'b0, 1'b0, 1'b0);
    drive(3'b001, 3'b000, 32'h404, 1'b0, 1'b1, 1'b0);
    idle(2);
    // loss and clr_lost in the same cycle: set wins
    drive(3'b100, 3'b000, 32'h500, 1'b0, 1'b0, 1'b0);
    drive(3'b100, 3'b000, 32'h504, 1'b0, 1'b0, 1'b1);
    drive(3'b000, 3'b000, 32'h0, 1'b0, 1'b1, 1'b1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
            ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000,
            $urandom,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 19) == 0));
    end
    drive(3'b000, 3'b000, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(2);

    @(posedge clk);
    @(negedge clk);
    #1 mon_en = 1'b0;
    check("pres_q_empty", 64'(pres_q.size()), 64'd0);
    check("stat_q_empty", 64'(stat_q.size()), 64'd0);

    // asynchronous reset while presenting
    @(posedge clk);
    #1 exc_req = 3'b001;
    pc_in = 32'h1234;
    @(posedge clk);
    #1 exc_req = 3'b000;
    exc_req = 3'b010;
    @(posedge clk);
    #1 exc_req = 3'b000;
    @(negedge clk);
    check("pre_reset_valid", {exc_valid, cause_out, epc_out}, {1'b1, 8'd0, 32'h1234});
    check("pre_reset_cnt", 64'(pend_cnt), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {exc_valid, cause_out, epc_out, vec_idx, pend_cnt, exc_lost}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset", {exc_valid, pend_cnt}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
